// File: rtl/flash_sched.sv
// flash_sched -- per-sample flash fetch scheduler and SPI bus owner arbiter.
//
// Each samp_ena starts a frame of NUM_CYC flash fetches (one per wavetable).
// Between frames the flash SPI bus can be handed to the MCU through the
// active-low mcu_req_l / mcu_ack_l handshake.
//
// Optional feature macro: FLASH_SCHED_WDOG_EN
//   defined   : per-fetch watchdog; a fetch without fetch_done for TIMEOUT
//               cycles after fetch_start aborts the frame and sets timeout.
//   undefined : WAIT waits indefinitely, timeout is tied to 0.
//
// Ports:
//   clk          system clock
//   reset_l      asynchronous active-low reset
//   samp_ena     one-cycle sample strobe
//   mcu_req_l    asynchronous MCU bus request (active low)
//   mcu_ack_l    MCU bus grant (active low)
//   fetch_start  one-cycle pulse starting one flash fetch
//   cyc_num      access cycle index within the frame, valid while busy
//   fetch_done   data-valid strobe from the flash engine
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last fetch of a frame
//   clr_stat     synchronous clear of overrun, skip_cnt, timeout
//   overrun      sticky: samp_ena arrived while busy
//   skip_cnt     saturating count of samp_ena received while MCU granted
//   timeout      sticky watchdog flag
module flash_sched #(
    parameter int unsigned NUM_CYC     = 3,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       samp_ena,
    input  logic       mcu_req_l,
    output logic       mcu_ack_l,
    output logic       fetch_start,
    output logic [1:0] cyc_num,
    input  logic       fetch_done,
    output logic       busy,
    output logic       frame_done,
    input  logic       clr_stat,
    output logic       overrun,
    output logic [7:0] skip_cnt,
    output logic       timeout
);

    if (NUM_CYC < 1 || NUM_CYC > 4 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
        TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
        $error("flash_sched: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_MCU
    } state_t;

    localparam logic [1:0] LAST_CYC = 2'(NUM_CYC - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             cyc_nxt;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   wdog_hit;
    logic                   frame_end;
    logic                   ovr_set;
    logic                   skip_inc;

    // Synchronizer resets to "not requesting" (line high).
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            req_sync <= '1;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], mcu_req_l};
        end
    end

    assign req_s = ~req_sync[SYNC_STAGES-1];

`ifdef FLASH_SCHED_WDOG_EN
    logic [7:0] wdog_cnt;

    // wdog_cnt holds the number of WAIT cycles already spent before the
    // current one; expiring at TIMEOUT-2 puts the return to IDLE exactly
    // TIMEOUT cycles after the fetch_start cycle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wdog_cnt <= '0;
        end else if (state == S_START) begin
            wdog_cnt <= '0;
        end else if (state == S_WAIT) begin
            wdog_cnt <= wdog_cnt + 8'd1;
        end
    end

    assign wdog_hit = (state == S_WAIT) && !fetch_done &&
                      (wdog_cnt == 8'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            timeout <= 1'b0;
        end else if (wdog_hit) begin
            timeout <= 1'b1;
        end else if (clr_stat) begin
            timeout <= 1'b0;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign frame_end = (state == S_WAIT) && fetch_done && (cyc_num == LAST_CYC);
    assign ovr_set   = samp_ena && ((state == S_START) || (state == S_WAIT));
    assign skip_inc  = samp_ena && (state == S_MCU);

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_num;
        case (state)
            S_IDLE: begin
                if (samp_ena) begin
                    state_nxt = S_START;
                    cyc_nxt   = '0;
                end else if (req_s) begin
                    state_nxt = S_MCU;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (fetch_done) begin
                    if (cyc_num == LAST_CYC) begin
                        state_nxt = S_IDLE;
                        cyc_nxt   = '0;
                    end else begin
                        state_nxt = S_START;
                        cyc_nxt   = cyc_num + 2'd1;
                    end
                end else if (wdog_hit) begin
                    state_nxt = S_IDLE;
                    cyc_nxt   = '0;
                end
            end
            S_MCU: begin
                if (!req_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            cyc_num     <= '0;
            fetch_start <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            mcu_ack_l   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cyc_num     <= cyc_nxt;
            fetch_start <= (state_nxt == S_START);
            busy        <= (state_nxt == S_START) || (state_nxt == S_WAIT);
            frame_done  <= frame_end;
            mcu_ack_l   <= (state_nxt != S_MCU);
        end
    end

    // Status flags: a setting event wins over clr_stat in the same cycle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            overrun  <= 1'b0;
            skip_cnt <= '0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_stat) begin
                overrun <= 1'b0;
            end

            if (skip_inc) begin
                if (clr_stat) begin
                    skip_cnt <= 8'd1;
                end else if (skip_cnt != 8'hFF) begin
                    skip_cnt <= skip_cnt + 8'd1;
                end
            end else if (clr_stat) begin
                skip_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_flash_sched.sv
// tb_flash_sched -- self-checking bench for flash_sched.
// Directed scenarios followed by randomized traffic; every cycle all outputs
// are compared against a transaction-level reference model of the scheduler.
// Watchdog scenario is built only with FLASH_SCHED_WDOG_EN defined.
module tb_flash_sched;

    localparam int NUM_CYC = 3;
    localparam int TMO     = 255;
    localparam int SYNC    = 2;
`ifdef FLASH_SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_l;
    logic       samp_ena;
    logic       mcu_req_l;
    logic       mcu_ack_l;
    logic       fetch_start;
    logic [1:0] cyc_num;
    logic       fetch_done;
    logic       busy;
    logic       frame_done;
    logic       clr_stat;
    logic       overrun;
    logic [7:0] skip_cnt;
    logic       timeout;

    flash_sched #(
        .NUM_CYC    (NUM_CYC),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .samp_ena   (samp_ena),
        .mcu_req_l  (mcu_req_l),
        .mcu_ack_l  (mcu_ack_l),
        .fetch_start(fetch_start),
        .cyc_num    (cyc_num),
        .fetch_done (fetch_done),
        .busy       (busy),
        .frame_done (frame_done),
        .clr_stat   (clr_stat),
        .overrun    (overrun),
        .skip_cnt   (skip_cnt),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_active;    // a frame is being fetched
    bit m_issued;    // current fetch has already been launched
    bit m_granted;   // MCU owns the bus
    int m_idx;       // wavetable index of current fetch
    int m_elapsed;   // cycles since the current fetch_start
    bit m_fs;
    bit m_fd;
    bit m_ov;
    bit m_to;
    int m_skip;
    bit req_line[$]; // delayed view of mcu_req_l

    task automatic model_reset();
        m_active = 0; m_issued = 0; m_granted = 0; m_idx = 0; m_elapsed = 0;
        m_fs = 0; m_fd = 0; m_ov = 0; m_to = 0; m_skip = 0;
        req_line.delete();
        for (int i = 0; i < SYNC; i++) req_line.push_back(1'b1);
    endtask

    task automatic model_step();
        bit rs, ov_set, to_set, sk_inc;
        rs = !req_line[0];
        void'(req_line.pop_front());
        req_line.push_back(mcu_req_l);
        m_fd = 0; ov_set = 0; to_set = 0; sk_inc = 0;
        if (m_active) begin
            if (samp_ena) ov_set = 1;
            m_elapsed++;
            if (!m_issued) begin
                m_issued = 1;
            end else if (fetch_done) begin
                if (m_idx < NUM_CYC - 1) begin
                    m_idx++; m_issued = 0; m_elapsed = 0;
                end else begin
                    m_active = 0; m_fd = 1; m_idx = 0;
                end
            end else if (WDOG && m_elapsed == TMO) begin
                m_active = 0; m_idx = 0; to_set = 1;
            end
        end else if (m_granted) begin
            if (samp_ena) sk_inc = 1;
            if (!rs) m_granted = 0;
        end else if (samp_ena) begin
            m_active = 1; m_issued = 0; m_idx = 0; m_elapsed = 0;
        end else if (rs) begin
            m_granted = 1;
        end
        m_fs = m_active && !m_issued;
        if (ov_set) m_ov = 1; else if (clr_stat) m_ov = 0;
        if (to_set) m_to = 1; else if (clr_stat) m_to = 0;
        if (sk_inc) m_skip = clr_stat ? 1 : (m_skip < 255 ? m_skip + 1 : 255);
        else if (clr_stat) m_skip = 0;
    endtask

    task automatic check_all();
        check("busy",        busy,        m_active);
        check("fetch_start", fetch_start, m_fs);
        check("cyc_num",     cyc_num,     8'(m_idx));
        check("frame_done",  frame_done,  m_fd);
        check("mcu_ack_l",   mcu_ack_l,   !m_granted);
        check("overrun",     overrun,     m_ov);
        check("skip_cnt",    skip_cnt,    8'(m_skip));
        check("timeout",     timeout,     m_to);
    endtask

    // ---------------- flash engine stand-in ----------------
    int rsp_cnt   = 0;
    int fixed_lat = 0;
    bit rsp_stall = 0;
    bit spurious  = 0;

    task automatic respond();
        fetch_done = 0;
        if (m_fs && !rsp_stall) begin
            rsp_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 12));
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) fetch_done = 1;
        end else if (spurious && $urandom_range(0, 49) == 0) begin
            fetch_done = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_l) model_step();
        check_all();
        samp_ena = 0;
        clr_stat = 0;
        if (reset_l) respond();
        else begin
            rsp_cnt = 0; fetch_done = 0;
        end
    endtask

    // Reset asserted between edges; outputs must drop without a clock edge.
    task automatic async_reset(input string tag);
        #3;
        reset_l = 0;
        #1;
        model_reset();
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_ack"},   mcu_ack_l, 1'b1);
        check({tag, "_stat"},  {overrun, timeout, frame_done, fetch_start}, 4'b0);
        check({tag, "_skip"},  skip_cnt,  8'd0);
        samp_ena = 0; clr_stat = 0; fetch_done = 0; rsp_cnt = 0;
        tick();
        tick();
        #2;
        reset_l = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n, lat, seen, lows;
        logic [5:0] seq;

        reset_l = 0; samp_ena = 0; mcu_req_l = 1; fetch_done = 0; clr_stat = 0;
        model_reset();
        tick();
        tick();
        #2;
        reset_l = 1;

        // Basic frame
        fixed_lat = 10;
        samp_ena = 1;
        tick();
        check("basic_first_fs", fetch_start, 1'b1);
        n = 1; seq = 6'(cyc_num); seen = 0; lows = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (fetch_start) begin
                seq = {seq[3:0], cyc_num};
                n++;
            end
            if (frame_done) seen = 1;
            else if (!busy) lows++;
        end
        check("basic_fs_cnt",  8'(n), 8'd3);
        check("basic_cyc_seq", 8'(seq), 8'b00_00_01_10);
        check("basic_done",    8'(seen), 8'd1);
        check("basic_busy",    8'(lows), 8'd0);
        tick();

        // Overrun during cyc_num=1
        samp_ena = 1;
        tick();
        for (int i = 0; i < 100 && !(busy && cyc_num == 2'd1); i++) tick();
        check("ovr_reach", cyc_num, 2'd1);
        samp_ena = 1;
        tick();
        check("ovr_set", overrun, 1'b1);
        n = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (fetch_start) n++;
            if (frame_done) seen = 1;
        end
        check("ovr_remaining_fs", 8'(n), 8'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_start) n++;
        end
        check("ovr_no_extra", 8'(n), 8'd0);
        clr_stat = 1;
        tick();
        check("ovr_clr", overrun, 1'b0);

        // MCU grant, skips, release
        mcu_req_l = 0;
        lat = 0;
        for (int i = 0; i < 10 && mcu_ack_l; i++) begin
            tick();
            lat++;
        end
        check("grant_lat", 8'(lat), 8'(SYNC + 1));
        n = 0;
        for (int i = 0; i < 300; i++) begin
            samp_ena = 1;
            tick();
            if (fetch_start) n++;
        end
        check("skip_sat", skip_cnt, 8'd255);
        check("skip_no_fs", 8'(n), 8'd0);
        samp_ena = 1; clr_stat = 1;
        tick();
        check("skip_set_wins", skip_cnt, 8'd1);
        mcu_req_l = 1;
        lat = 0;
        for (int i = 0; i < 10 && !mcu_ack_l; i++) begin
            tick();
            lat++;
        end
        check("release_lat", 8'(lat), 8'(SYNC + 1));
        clr_stat = 1;
        tick();

        // samp_ena and synchronized request in the same cycle
        fixed_lat = 5;
        mcu_req_l = 0;
        for (int i = 0; i < SYNC; i++) tick();
        samp_ena = 1;
        tick();
        check("prio_frame_first", fetch_start, 1'b1);
        check("prio_no_grant", mcu_ack_l, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (frame_done) seen = 1;
        end
        check("prio_done", 8'(seen), 8'd1);
        tick();
        check("prio_ack_after", mcu_ack_l, 1'b0);
        mcu_req_l = 1;
        for (int i = 0; i < 6; i++) tick();

        // Request raised mid-frame is deferred
        samp_ena = 1;
        tick();
        for (int i = 0; i < 12; i++) tick();
        mcu_req_l = 0;
        seen = 0; lows = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (!mcu_ack_l) lows++;
            if (frame_done) seen = 1;
        end
        check("defer_no_early", 8'(lows), 8'd0);
        tick();
        check("defer_ack", mcu_ack_l, 1'b0);
        mcu_req_l = 1;
        for (int i = 0; i < 6; i++) tick();

`ifdef FLASH_SCHED_WDOG_EN
        // Watchdog: fetch never completes
        rsp_stall = 1;
        samp_ena = 1;
        tick();
        n = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            tick();
            n++;
        end
        check("wdog_lat", 8'(n), 8'(TMO));
        check("wdog_flag", timeout, 1'b1);
        check("wdog_no_done", frame_done, 1'b0);
        rsp_stall = 0;
        samp_ena = 1;
        tick();
        check("wdog_restart_cyc", cyc_num, 2'd0);
        check("wdog_restart_fs", fetch_start, 1'b1);
        for (int i = 0; i < 60; i++) tick();
        clr_stat = 1;
        tick();
`endif

        // Async reset mid-WAIT with overrun pending
        fixed_lat = 10;
        samp_ena = 1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        samp_ena = 1;
        tick();
        check("rst_pre_ovr", overrun, 1'b1);
        async_reset("rst_wait");

        // Async reset during a grant
        mcu_req_l = 0;
        for (int i = 0; i < 6; i++) tick();
        samp_ena = 1;
        tick();
        check("rst_pre_grant", mcu_ack_l, 1'b0);
        async_reset("rst_grant");
        mcu_req_l = 1;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic
        fixed_lat = 0;
        spurious = 1;
        for (int i = 0; i < 3000; i++) begin
            samp_ena = ($urandom_range(0, 19) == 0);
            clr_stat = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) mcu_req_l = ~mcu_req_l;
            tick();
        end
        spurious = 0;
        mcu_req_l = 1;
        for (int i = 0; i < 60; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
